// File: rtl/tap_period_counter.sv
// Measures the interval between successive debounced taps in time-pulse ticks,
// rejecting short (bounce) intervals and timing out when no second tap arrives.
module tap_period_counter #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MAX_COUNT   = 65535,
  parameter int unsigned MIN_COUNT   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tp_i,
  input  logic                   btn_i,
  output logic [COUNT_WIDTH-1:0] per_o,
  output logic                   per_valid_o,
  output logic                   timeout_o,
  output logic                   counting_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [COUNT_WIDTH-1:0] MIN_C = COUNT_WIDTH'(MIN_COUNT);

  logic [0:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] per_q, per_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   counting_q, counting_d;

  // State and output registers; reset is synchronous and active-low.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      counting_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      counting_q <= counting_d;
    end
  end

  // Next-state logic: a valid tap takes priority over a same-cycle timeout tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (btn_i) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (btn_i && (cnt_q >= MIN_C)) begin
          per_d   = cnt_q;
          valid_d = 1'b1;
          // A coincident tick is the first tick of the new period.
          cnt_d   = {{(COUNT_WIDTH-1){1'b0}}, tp_i};
        end else if (tp_i && (cnt_q == MAX_C)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (tp_i) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    counting_d = (state_d == S_COUNT);
  end

  assign per_o       = per_q;
  assign per_valid_o = valid_q;
  assign timeout_o   = timeout_q;
  assign counting_o  = counting_q;

endmodule

// File: tb/tb_tap_period_counter.sv
// Bench for tap_period_counter: a default instance and a short-timeout instance
// share stimulus and are checked against a tick-counting reference model.
module tb_tap_period_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b0;
  logic        tp  = 1'b0;
  logic [15:0] per_a, per_b;
  logic        val_a, val_b, to_a, to_b, cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tap_period_counter dut_a (
    .clk_i(clk), .rst_i(rst), .tp_i(tp), .btn_i(btn),
    .per_o(per_a), .per_valid_o(val_a), .timeout_o(to_a), .counting_o(cnt_a)
  );

  tap_period_counter #(.COUNT_WIDTH(16), .MAX_COUNT(10), .MIN_COUNT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .tp_i(tp), .btn_i(btn),
    .per_o(per_b), .per_valid_o(val_b), .timeout_o(to_b), .counting_o(cnt_b)
  );

  // Reference: whether a period is open and how many ticks it has accumulated.
  localparam int MIN_T = 4;
  int m_max[2]   = '{65535, 10};
  bit m_open[2]  = '{0, 0};
  int m_ticks[2] = '{0, 0};
  int m_per[2]   = '{0, 0};
  bit m_v[2]     = '{0, 0};
  bit m_t[2]     = '{0, 0};

  typedef struct {
    logic        rst, btn, tp;
    logic [15:0] per;
    logic        v, t, c;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int i, input logic r, input logic b, input logic t);
    m_v[i] = 0;
    m_t[i] = 0;
    if (!r) begin
      m_open[i] = 0; m_ticks[i] = 0; m_per[i] = 0;
    end else if (!m_open[i]) begin
      if (b) begin m_open[i] = 1; m_ticks[i] = 0; end
    end else if (b && m_ticks[i] >= MIN_T) begin
      m_per[i] = m_ticks[i]; m_v[i] = 1; m_ticks[i] = t ? 1 : 0;
    end else if (t && m_ticks[i] == m_max[i]) begin
      m_t[i] = 1; m_open[i] = 0; m_ticks[i] = 0;
    end else if (t) begin
      m_ticks[i] = m_ticks[i] + 1;
    end
  endtask

  // Apply one cycle of inputs, then compare both instances with the model.
  task automatic step(input logic r, input logic b, input logic t);
    @(negedge clk);
    rst = r; btn = b; tp = t;
    @(posedge clk);
    #1;
    model(0, r, b, t);
    model(1, r, b, t);
    chk("a.per",      int'(per_a), m_per[0]);
    chk("a.valid",    int'(val_a), int'(m_v[0]));
    chk("a.timeout",  int'(to_a),  int'(m_t[0]));
    chk("a.counting", int'(cnt_a), int'(m_open[0]));
    chk("b.per",      int'(per_b), m_per[1]);
    chk("b.valid",    int'(val_b), int'(m_v[1]));
    chk("b.timeout",  int'(to_b),  int'(m_t[1]));
    chk("b.counting", int'(cnt_b), int'(m_open[1]));
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic add(input logic r, input logic b, input logic t, input int p,
                     input logic v, input logic to, input logic c, input int n);
    vec_t e;
    e.rst = r; e.btn = b; e.tp = t; e.per = 16'(p); e.v = v; e.t = to; e.c = c;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  initial begin
    // Hand-derived vectors for the MAX_COUNT=10 instance.
    add(0, 1, 1,  0, 0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 1);
    add(0, 1, 0,  0, 0, 0, 0, 1);
    add(1, 1, 0,  0, 0, 0, 1, 1);
    add(1, 0, 1,  0, 0, 0, 1, 4);
    add(1, 1, 0,  4, 1, 0, 1, 1);
    add(1, 1, 1,  4, 0, 0, 1, 1);
    add(1, 0, 1,  4, 0, 0, 1, 9);
    add(1, 0, 1,  4, 0, 1, 0, 1);
    add(1, 0, 1,  4, 0, 0, 0, 1);
    add(1, 1, 0,  4, 0, 0, 1, 1);
    add(1, 0, 1,  4, 0, 0, 1, 10);
    add(1, 1, 1, 10, 1, 0, 1, 1);
    add(1, 0, 0, 10, 0, 0, 1, 1);
    add(0, 1, 1,  0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn, tbl[i].tp);
      chk("tbl.per",      int'(per_b), int'(tbl[i].per));
      chk("tbl.valid",    int'(val_b), int'(tbl[i].v));
      chk("tbl.timeout",  int'(to_b),  int'(tbl[i].t));
      chk("tbl.counting", int'(cnt_b), int'(tbl[i].c));
    end

    // Basic period then a back-to-back second period.
    step(1, 0, 0);
    step(1, 1, 0);
    pulses(100);
    step(1, 1, 0);
    chk("basic.per100", int'(per_a), 100);
    chk("basic.strobe", int'(val_a), 1);
    step(1, 0, 0);
    chk("basic.strobe_once", int'(val_a), 0);
    chk("basic.counting", int'(cnt_a), 1);
    pulses(50);
    step(1, 1, 0);
    chk("basic.per50", int'(per_a), 50);

    // Bounce rejection: a tap after 2 ticks does not close the period.
    step(0, 0, 0);
    step(1, 1, 0);
    pulses(2);
    step(1, 1, 0);
    chk("bounce.no_strobe", int'(val_a), 0);
    pulses(10);
    step(1, 1, 0);
    chk("bounce.per12", int'(per_a), 12);
    chk("bounce.strobe", int'(val_a), 1);

    // Simultaneous tap and tick.
    step(0, 0, 0);
    step(1, 1, 0);
    pulses(20);
    step(1, 1, 1);
    chk("simul.per20", int'(per_a), 20);
    pulses(5);
    step(1, 1, 0);
    chk("simul.per6", int'(per_a), 6);

    // Timeout on the short instance, then a fresh first tap.
    step(1, 1, 0);
    pulses(10);
    chk("timeout.pre", int'(to_b), 0);
    step(1, 0, 1);
    chk("timeout.pulse", int'(to_b), 1);
    chk("timeout.counting", int'(cnt_b), 0);
    chk("timeout.per_held", int'(per_b), 5);
    step(1, 1, 0);
    chk("timeout.first_tap", int'(val_b), 0);

    // Reset mid-measurement discards the pending count.
    step(1, 1, 0);
    pulses(30);
    step(0, 0, 0);
    chk("rstmid.no_strobe", int'(val_a), 0);
    chk("rstmid.per", int'(per_a), 0);
    step(1, 1, 0);
    pulses(7);
    step(1, 1, 0);
    chk("rstmid.per7", int'(per_a), 7);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 599) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
